ibias_startup_seq: RTL and testbench
====================================

Name: ibias_startup_seq

Overview:
Digital power-up sequencer that drives the enable, startup and trim pins of the IO-domain bandgap/bias cell. It consumes that cell's BG_VALID output and produces a qualified READY flag for downstream IO and analog consumers. It sits in the core VDD domain, directly upstream of the bias cell.

Parameters:
STARTUP_CYC, 16, cycles BG_STARTUP_O is held high per startup attempt (>=1)
TIMEOUT_CYC, 1024, max cycles in WAIT_VALID before timeout (>=1)
SETTLE_CYC, 256, cycles synchronized valid must stay high before READY (>=1)
CNT_W, 12, counter width; must hold max(STARTUP_CYC, TIMEOUT_CYC, SETTLE_CYC)-1
TRIM_IBIAS_RST, 5'd16, reset/default IBIAS trim code
TRIM_VBIAS_RST, 4'd8, reset/default VBIAS trim code
MAX_RETRY, 3, automatic retries after timeout (used only with the optional feature)

Ports:
CLK_I  in  1  core clock
RSTN_I  in  1  reset, asynchronous assert, active-low
REQ_IBIAS_I  in  1  request for the current-bias outputs
REQ_VBIAS_I  in  1  request for the VBIAS output
TRIM_IBIAS_I  in  5  new IBIAS trim code
TRIM_VBIAS_I  in  4  new VBIAS trim code
TRIM_LOAD_I  in  1  single-cycle strobe that captures both trim inputs
BG_VALID_I  in  1  BG_VALID from the bias cell; asynchronous to CLK_I
EN_IBIAS_O  out  1  to the cell's EN_IBIAS_I
EN_VBIAS_O  out  1  to the cell's EN_VBIAS_I
BG_STARTUP_O  out  1  to the cell's BG_STARTUP_I
TRIM_IBIAS_O  out  5  to the cell's TRIM_IBIAS_I
TRIM_VBIAS_O  out  4  to the cell's TRIM_VBIAS_I
READY_O  out  1  bias qualified and settled
FAULT_O  out  1  startup timeout; sticky until requests are dropped
STATE_O  out  3  state encoding, for debug

Behaviour:
- Reset values: all 1-bit outputs 0; TRIM_IBIAS_O=TRIM_IBIAS_RST; TRIM_VBIAS_O=TRIM_VBIAS_RST; STATE_O=OFF; counter 0; synchronizer 0; pending-trim flag 0.
- BG_VALID_I passes through a 2-flop synchronizer, giving vs. All outputs are registered.
- req = REQ_IBIAS_I | REQ_VBIAS_I.
- States and STATE_O encoding: OFF=0, STARTUP=1, WAIT_VALID=2, SETTLE=3, READY=4, FAULT=5.
- Global rule: in any state other than OFF, req=0 forces OFF on the next clock and clears the counter. This rule takes priority over every other transition.
- OFF: on req=1, go to STARTUP with cnt=0.
- STARTUP: BG_STARTUP_O=1. At cnt==STARTUP_CYC-1, go to WAIT_VALID with cnt=0.
- WAIT_VALID:
  - vs=1: go to SETTLE with cnt=0.
  - Otherwise, at cnt==TIMEOUT_CYC-1: go to FAULT.
- SETTLE:
  - vs=0: go back to WAIT_VALID with cnt=0, keeping the timeout budget fresh.
  - At cnt==SETTLE_CYC-1: go to READY.
- READY: READY_O=1. On vs=0, go to STARTUP with cnt=0; READY_O drops on that same clock edge.
- FAULT: FAULT_O=1, all enables 0, BG_STARTUP_O=0. The only exit is req=0, which goes to OFF.
- Enables: EN_IBIAS_O and EN_VBIAS_O are registered copies of REQ_IBIAS_I and REQ_VBIAS_I in STARTUP through READY, and 0 in OFF and FAULT.
  - Changing which request is set while req stays 1 updates the enables only. It does not restart the sequence.
- Trim capture:
  - TRIM_LOAD_I=1 captures both trim inputs into shadow registers in any state.
  - Outside STARTUP, the captured values reach the trim outputs on the next clock.
  - In STARTUP, the update is held pending and applied on the clock that leaves STARTUP.
  - A later load overwrites the pending value (last value wins).
- Counter: CNT_W bits; never wraps within a state, because every terminal count causes a state exit.
- Reset asserted mid-operation returns every register asynchronously to its reset value, including the trim registers.

Optional Feature:
IBIAS_SEQ_RETRY_EN.
- Defined: adds a retry counter, 0..MAX_RETRY.
  - A WAIT_VALID timeout with retry<MAX_RETRY goes to STARTUP and increments retry.
  - A timeout with retry==MAX_RETRY goes to FAULT.
  - retry clears on entry to READY or OFF.
- Undefined: a timeout always goes to FAULT; no retry logic is instantiated and MAX_RETRY is ignored.

Test Plan:
- Reset, then REQ_IBIAS_I=1; BG_VALID_I rises 3 cycles after BG_STARTUP_O falls -> BG_STARTUP_O high exactly 16 cycles; READY_O=1 exactly 256 cycles after vs rises; EN_IBIAS_O=1, EN_VBIAS_O=0, STATE_O=4.
- REQ_VBIAS_I=1 with BG_VALID_I held 0 -> without macro: FAULT_O=1 1024 cycles after WAIT_VALID entry, enables 0. With macro: 4 BG_STARTUP_O pulses, then FAULT_O. Dropping REQ_VBIAS_I -> STATE_O=0, FAULT_O=0.
- In READY, pull BG_VALID_I low for 5 cycles -> READY_O=0 within 3 cycles, a new 16-cycle BG_STARTUP_O pulse follows, and READY is regained after vs returns high.
- TRIM_LOAD_I with 5'd3/4'd12 during STARTUP -> trim outputs hold 16/8 until WAIT_VALID entry, then 3/12. A load in READY updates the outputs on the next clock.
- Glitch BG_VALID_I low for 4 cycles during SETTLE -> back to WAIT_VALID, settle counter restarts, READY_O delayed by a full 256 cycles.
- Assert RSTN_I mid-SETTLE with trims at 3/12 -> all outputs immediately at reset values, trims back to 16/8, STATE_O=0.

Source files
------------

// File: rtl/ibias_startup_seq.sv
// Power-up sequencer for the IO-domain bandgap/bias cell: enable, startup pulse, trim and READY.
// Optional macro IBIAS_SEQ_RETRY_EN adds automatic startup retries after a WAIT_VALID timeout.
module ibias_startup_seq #(
   parameter int unsigned STARTUP_CYC    = 16,
   parameter int unsigned TIMEOUT_CYC    = 1024,
   parameter int unsigned SETTLE_CYC     = 256,
   parameter int unsigned CNT_W          = 12,
   parameter logic [4:0]  TRIM_IBIAS_RST = 5'd16,
   parameter logic [3:0]  TRIM_VBIAS_RST = 4'd8,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic       CLK_I,
   input  logic       RSTN_I,
   input  logic       REQ_IBIAS_I,
   input  logic       REQ_VBIAS_I,
   input  logic [4:0] TRIM_IBIAS_I,
   input  logic [3:0] TRIM_VBIAS_I,
   input  logic       TRIM_LOAD_I,
   input  logic       BG_VALID_I,
   output logic       EN_IBIAS_O,
   output logic       EN_VBIAS_O,
   output logic       BG_STARTUP_O,
   output logic [4:0] TRIM_IBIAS_O,
   output logic [3:0] TRIM_VBIAS_O,
   output logic       READY_O,
   output logic       FAULT_O,
   output logic [2:0] STATE_O
);

   typedef enum logic [2:0] {
      S_OFF        = 3'd0,
      S_STARTUP    = 3'd1,
      S_WAIT_VALID = 3'd2,
      S_SETTLE     = 3'd3,
      S_READY      = 3'd4,
      S_FAULT      = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       sync_q, sync_d;
   logic             en_ibias_q, en_ibias_d;
   logic             en_vbias_q, en_vbias_d;
   logic             bg_startup_q, bg_startup_d;
   logic             ready_q, ready_d;
   logic             fault_q, fault_d;
   logic [4:0]       trim_ibias_q, trim_ibias_d;
   logic [3:0]       trim_vbias_q, trim_vbias_d;
   logic [4:0]       shadow_ibias_q, shadow_ibias_d;
   logic [3:0]       shadow_vbias_q, shadow_vbias_d;
   logic             pend_q, pend_d;
   logic             req;
   logic             vs;
   logic             active;
   logic             eff_pend;
   logic [4:0]       eff_ibias;
   logic [3:0]       eff_vbias;

`ifdef IBIAS_SEQ_RETRY_EN
   localparam int unsigned RTY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RTY_W-1:0] RETRY_LAST = RTY_W'(MAX_RETRY);
   logic [RTY_W-1:0] retry_q, retry_d;
`endif

   assign req = REQ_IBIAS_I | REQ_VBIAS_I;
   assign vs  = sync_q[1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef IBIAS_SEQ_RETRY_EN
      retry_d = retry_q;
`endif
      case (state_q)
         S_OFF: begin
            cnt_d = '0;
            if (req) state_d = S_STARTUP;
         end
         S_STARTUP: begin
            if (cnt_q == STARTUP_LAST) begin
               state_d = S_WAIT_VALID;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_VALID: begin
            if (vs) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               cnt_d = '0;
`ifdef IBIAS_SEQ_RETRY_EN
               if (retry_q != RETRY_LAST) begin
                  state_d = S_STARTUP;
                  retry_d = retry_q + 1'b1;
               end else begin
                  state_d = S_FAULT;
               end
`else
               state_d = S_FAULT;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SETTLE: begin
            // A dropout restarts the wait with a fresh timeout budget.
            if (!vs) begin
               state_d = S_WAIT_VALID;
               cnt_d   = '0;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = S_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_READY: begin
            cnt_d = '0;
            if (!vs) state_d = S_STARTUP;
         end
         S_FAULT: cnt_d = '0;
         default: begin
            state_d = S_OFF;
            cnt_d   = '0;
         end
      endcase
      if (state_q != S_OFF && !req) begin
         state_d = S_OFF;
         cnt_d   = '0;
      end
`ifdef IBIAS_SEQ_RETRY_EN
      if (state_d == S_OFF || state_d == S_READY) retry_d = '0;
`endif
   end

   // Outputs are registered copies of what the next state implies.
   always_comb begin
      active       = (state_d == S_STARTUP) || (state_d == S_WAIT_VALID) ||
                     (state_d == S_SETTLE)  || (state_d == S_READY);
      en_ibias_d   = active & REQ_IBIAS_I;
      en_vbias_d   = active & REQ_VBIAS_I;
      bg_startup_d = (state_d == S_STARTUP);
      ready_d      = (state_d == S_READY);
      fault_d      = (state_d == S_FAULT);
      sync_d       = {sync_q[0], BG_VALID_I};
   end

   // A load seen while startup continues stays pending; it lands on the edge leaving STARTUP.
   always_comb begin
      eff_pend       = TRIM_LOAD_I | pend_q;
      eff_ibias      = TRIM_LOAD_I ? TRIM_IBIAS_I : shadow_ibias_q;
      eff_vbias      = TRIM_LOAD_I ? TRIM_VBIAS_I : shadow_vbias_q;
      shadow_ibias_d = eff_ibias;
      shadow_vbias_d = eff_vbias;
      trim_ibias_d   = trim_ibias_q;
      trim_vbias_d   = trim_vbias_q;
      pend_d         = eff_pend;
      if (eff_pend && state_d != S_STARTUP) begin
         trim_ibias_d = eff_ibias;
         trim_vbias_d = eff_vbias;
         pend_d       = 1'b0;
      end
   end

   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         state_q        <= S_OFF;
         cnt_q          <= '0;
         sync_q         <= '0;
         en_ibias_q     <= 1'b0;
         en_vbias_q     <= 1'b0;
         bg_startup_q   <= 1'b0;
         ready_q        <= 1'b0;
         fault_q        <= 1'b0;
         trim_ibias_q   <= TRIM_IBIAS_RST;
         trim_vbias_q   <= TRIM_VBIAS_RST;
         shadow_ibias_q <= TRIM_IBIAS_RST;
         shadow_vbias_q <= TRIM_VBIAS_RST;
         pend_q         <= 1'b0;
`ifdef IBIAS_SEQ_RETRY_EN
         retry_q        <= '0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         sync_q         <= sync_d;
         en_ibias_q     <= en_ibias_d;
         en_vbias_q     <= en_vbias_d;
         bg_startup_q   <= bg_startup_d;
         ready_q        <= ready_d;
         fault_q        <= fault_d;
         trim_ibias_q   <= trim_ibias_d;
         trim_vbias_q   <= trim_vbias_d;
         shadow_ibias_q <= shadow_ibias_d;
         shadow_vbias_q <= shadow_vbias_d;
         pend_q         <= pend_d;
`ifdef IBIAS_SEQ_RETRY_EN
         retry_q        <= retry_d;
`endif
      end
   end

   assign EN_IBIAS_O   = en_ibias_q;
   assign EN_VBIAS_O   = en_vbias_q;
   assign BG_STARTUP_O = bg_startup_q;
   assign TRIM_IBIAS_O = trim_ibias_q;
   assign TRIM_VBIAS_O = trim_vbias_q;
   assign READY_O      = ready_q;
   assign FAULT_O      = fault_q;
   assign STATE_O      = state_q;

endmodule

// File: tb/tb_ibias_startup_seq.sv
// Scoreboard bench for ibias_startup_seq (default build): stimulus queues expected outputs, a monitor compares.
module tb_ibias_startup_seq;

   logic       CLK_I = 1'b0;
   logic       RSTN_I;
   logic       REQ_IBIAS_I, REQ_VBIAS_I, TRIM_LOAD_I, BG_VALID_I;
   logic [4:0] TRIM_IBIAS_I;
   logic [3:0] TRIM_VBIAS_I;
   logic       EN_IBIAS_O, EN_VBIAS_O, BG_STARTUP_O, READY_O, FAULT_O;
   logic [4:0] TRIM_IBIAS_O;
   logic [3:0] TRIM_VBIAS_O;
   logic [2:0] STATE_O;

   always #5 CLK_I = ~CLK_I;

   ibias_startup_seq dut (
      .CLK_I(CLK_I), .RSTN_I(RSTN_I),
      .REQ_IBIAS_I(REQ_IBIAS_I), .REQ_VBIAS_I(REQ_VBIAS_I),
      .TRIM_IBIAS_I(TRIM_IBIAS_I), .TRIM_VBIAS_I(TRIM_VBIAS_I), .TRIM_LOAD_I(TRIM_LOAD_I),
      .BG_VALID_I(BG_VALID_I),
      .EN_IBIAS_O(EN_IBIAS_O), .EN_VBIAS_O(EN_VBIAS_O), .BG_STARTUP_O(BG_STARTUP_O),
      .TRIM_IBIAS_O(TRIM_IBIAS_O), .TRIM_VBIAS_O(TRIM_VBIAS_O),
      .READY_O(READY_O), .FAULT_O(FAULT_O), .STATE_O(STATE_O)
   );

   typedef struct {
      int unsigned cyc;
      string       name;
      logic [16:0] exp;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic [16:0] obs;

   // Field order: state, fault, ready, startup, en_vbias, en_ibias, trim_ibias, trim_vbias
   assign obs = {STATE_O, FAULT_O, READY_O, BG_STARTUP_O, EN_VBIAS_O, EN_IBIAS_O,
                 TRIM_IBIAS_O, TRIM_VBIAS_O};

   logic [2:0] e_st;
   logic       e_flt, e_rdy, e_stu, e_env, e_eni;
   logic [4:0] e_ti;
   logic [3:0] e_tv;

   always @(posedge CLK_I) cyc <= cyc + 1;

   always @(negedge CLK_I) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         checks++;
         if (mon_e.cyc != cyc) begin
            failures++;
            $display("FAIL %s: not sampled at cycle %0d (now %0d)", mon_e.name, mon_e.cyc, cyc);
         end else if (obs !== mon_e.exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", mon_e.name, cyc, obs, mon_e.exp);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge CLK_I);
      #1;
   endtask

   task automatic set_e(input logic [2:0] st, input logic flt, input logic rdy,
                        input logic stu, input logic env, input logic eni);
      e_st = st; e_flt = flt; e_rdy = rdy; e_stu = stu; e_env = env; e_eni = eni;
   endtask

   task automatic chk(input string name);
      exp_t e;
      e.cyc  = cyc;
      e.name = name;
      e.exp  = {e_st, e_flt, e_rdy, e_stu, e_env, e_eni, e_ti, e_tv};
      sb.push_back(e);
   endtask

   task automatic wait_state(input logic [2:0] target, input int limit, input string name);
      int n;
      n = 0;
      while (STATE_O !== target && n < limit) begin
         step(1);
         n++;
      end
      if (STATE_O !== target) begin
         checks++;
         failures++;
         $display("FAIL %s: state=%0d after %0d cycles, need %0d", name, STATE_O, n, target);
      end
   endtask

   initial begin
      RSTN_I = 1'b0; REQ_IBIAS_I = 1'b0; REQ_VBIAS_I = 1'b0; TRIM_LOAD_I = 1'b0;
      BG_VALID_I = 1'b0; TRIM_IBIAS_I = '0; TRIM_VBIAS_I = '0;
      set_e(3'd0, 0, 0, 0, 0, 0); e_ti = 5'd16; e_tv = 4'd8;
      step(2);
      chk("reset_state");
      RSTN_I = 1'b1;
      step(1);
      chk("idle_after_reset");

      // Power-up with IBIAS request; trim loaded mid-startup stays pending.
      REQ_IBIAS_I = 1'b1;
      step(1);
      set_e(3'd1, 0, 0, 1, 0, 1);
      chk("startup_enter");
      for (int i = 2; i <= 16; i++) begin
         step(1);
         if (i == 5) begin
            TRIM_LOAD_I = 1'b0; TRIM_IBIAS_I = 5'd0; TRIM_VBIAS_I = 4'd0;
         end
         chk("startup_hold");
         if (i == 4) begin
            TRIM_LOAD_I = 1'b1; TRIM_IBIAS_I = 5'd3; TRIM_VBIAS_I = 4'd12;
         end
      end
      step(1);
      set_e(3'd2, 0, 0, 0, 0, 1); e_ti = 5'd3; e_tv = 4'd12;
      chk("wait_enter_trim_applied");
      step(3);
      chk("wait_hold");
      BG_VALID_I = 1'b1;
      step(2);
      chk("wait_sync_latency");
      step(1);
      e_st = 3'd3;
      chk("settle_enter");
      step(255);
      chk("settle_last");
      step(1);
      set_e(3'd4, 0, 1, 0, 0, 1);
      chk("ready_ibias");

      // Valid dropout in READY for 5 cycles.
      BG_VALID_I = 1'b0;
      step(2);
      chk("ready_sync_hold");
      step(1);
      set_e(3'd1, 0, 0, 1, 0, 1);
      chk("ready_drop_restart");
      step(2);
      BG_VALID_I = 1'b1;
      step(13);
      chk("restart_pulse_end");
      step(1);
      set_e(3'd2, 0, 0, 0, 0, 1);
      chk("restart_wait");
      step(1);
      e_st = 3'd3;
      chk("restart_settle");
      step(255);
      chk("restart_settle_last");
      step(1);
      set_e(3'd4, 0, 1, 0, 0, 1);
      chk("ready_regained");

      // Request change in READY only moves enables; load in READY lands next clock.
      REQ_VBIAS_I = 1'b1;
      step(1);
      e_env = 1'b1;
      chk("en_vbias_no_restart");
      TRIM_IBIAS_I = 5'd9; TRIM_VBIAS_I = 4'd2; TRIM_LOAD_I = 1'b1;
      step(1);
      TRIM_LOAD_I = 1'b0;
      e_ti = 5'd9; e_tv = 4'd2;
      chk("trim_ready_load");

      REQ_IBIAS_I = 1'b0; REQ_VBIAS_I = 1'b0;
      step(1);
      set_e(3'd0, 0, 0, 0, 0, 0);
      chk("req_drop_off");
      TRIM_IBIAS_I = 5'd3; TRIM_VBIAS_I = 4'd12; TRIM_LOAD_I = 1'b1;
      step(1);
      TRIM_LOAD_I = 1'b0;
      e_ti = 5'd3; e_tv = 4'd12;
      chk("trim_off_load");

      // Glitch during SETTLE restarts the settle window.
      REQ_IBIAS_I = 1'b1;
      step(1);
      set_e(3'd1, 0, 0, 1, 0, 1);
      chk("startup2_enter");
      step(16);
      set_e(3'd2, 0, 0, 0, 0, 1);
      chk("startup2_wait");
      step(1);
      e_st = 3'd3;
      chk("settle2_enter");
      step(10);
      BG_VALID_I = 1'b0;
      step(3);
      e_st = 3'd2;
      chk("glitch_back_to_wait");
      step(1);
      BG_VALID_I = 1'b1;
      step(3);
      e_st = 3'd3;
      chk("glitch_resettle");
      step(255);
      chk("glitch_settle_last");
      step(1);
      set_e(3'd4, 0, 1, 0, 0, 1);
      chk("ready_after_glitch");

      // Async reset mid-SETTLE.
      BG_VALID_I = 1'b0;
      step(1);
      BG_VALID_I = 1'b1;
      wait_state(3'd3, 40, "reach_settle");
      set_e(3'd3, 0, 0, 0, 0, 1);
      chk("settle3");
      step(5);
      RSTN_I = 1'b0;
      #1;
      set_e(3'd0, 0, 0, 0, 0, 0); e_ti = 5'd16; e_tv = 4'd8;
      chk("async_reset");
      REQ_IBIAS_I = 1'b0; BG_VALID_I = 1'b0;
      step(1);
      RSTN_I = 1'b1;
      step(1);
      chk("reset_release_idle");

      // Timeout to FAULT with BG_VALID held low.
      REQ_VBIAS_I = 1'b1;
      step(1);
      set_e(3'd1, 0, 0, 1, 1, 0);
      chk("fault_startup");
      step(16);
      set_e(3'd2, 0, 0, 0, 1, 0);
      chk("fault_wait_enter");
      step(1023);
      chk("timeout_last");
      step(1);
      set_e(3'd5, 1, 0, 0, 0, 0);
      chk("fault_enter");
      step(3);
      chk("fault_sticky");
      REQ_VBIAS_I = 1'b0;
      step(1);
      set_e(3'd0, 0, 0, 0, 0, 0);
      chk("fault_clear");

      step(2);
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d left, need 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
